// File: rtl/downlink_frame_capture.sv
// Captures one A22 downlink frame (order bit + two 16-bit words, MSB first), checks odd
// parity on each word and holds the last complete frame until the next one finishes.
module downlink_frame_capture #(
   parameter int unsigned TIMEOUT = 512,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             CLOCK,
   input  logic             rst,
   input  logic             DKSTRT,
   input  logic             DKBSNC,
   input  logic             DKDATA,
   output logic             FRAME_VALID,
   output logic             ORDER_BIT,
   output logic [15:0]      WORD1,
   output logic [15:0]      WORD2,
   output logic             PAR_ERR1,
   output logic             PAR_ERR2,
   output logic             BUSY,
   output logic             ABORT,
   output logic [CNT_W-1:0] FRAME_CNT,
   output logic [CNT_W-1:0] ABORT_CNT
);

   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ORDER = 3'd1;
   localparam logic [2:0] S_WORD1 = 3'd2;
   localparam logic [2:0] S_WORD2 = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic             r_s, r_s_prev, r_b, r_b_prev, r_d;
   logic [2:0]       r_state;
   logic [3:0]       r_bitcnt;
   logic [TMO_W-1:0] r_tmo;
   logic [15:0]      r_shift;
   logic [15:0]      r_w1;
   logic [15:0]      r_w2;
   logic             r_order;

   logic        w_start;
   logic        w_bit;
   logic        w_restart;
   logic [15:0] w_word;

   assign w_start   = r_s & ~r_s_prev;
   assign w_bit     = r_b & ~r_b_prev;
   assign w_word    = {r_shift[14:0], r_d};
   // A start edge in DONE is deferred; everywhere else it (re)starts a frame.
   assign w_restart = w_start && (r_state != S_DONE);
   assign BUSY      = (r_state != S_IDLE);

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         r_s         <= 1'b0;
         r_s_prev    <= 1'b0;
         r_b         <= 1'b0;
         r_b_prev    <= 1'b0;
         r_d         <= 1'b0;
         r_state     <= S_IDLE;
         r_bitcnt    <= 4'd0;
         r_tmo       <= '0;
         r_shift     <= 16'd0;
         r_w1        <= 16'd0;
         r_w2        <= 16'd0;
         r_order     <= 1'b0;
         FRAME_VALID <= 1'b0;
         ORDER_BIT   <= 1'b0;
         WORD1       <= 16'd0;
         WORD2       <= 16'd0;
         PAR_ERR1    <= 1'b0;
         PAR_ERR2    <= 1'b0;
         ABORT       <= 1'b0;
         FRAME_CNT   <= '0;
         ABORT_CNT   <= '0;
      end else begin
         r_s         <= DKSTRT;
         r_s_prev    <= r_s;
         r_b         <= DKBSNC;
         r_b_prev    <= r_b;
         r_d         <= DKDATA;
         FRAME_VALID <= 1'b0;
         ABORT       <= 1'b0;

         if (w_restart) begin
            if (r_state != S_IDLE) begin
               ABORT     <= 1'b1;
               ABORT_CNT <= ABORT_CNT + CNT_W'(1);
            end
            r_tmo    <= '0;
            r_bitcnt <= 4'd0;
            // A bit edge coinciding with the start edge is the order bit.
            if (w_bit) begin
               r_order <= r_d;
               r_state <= S_WORD1;
            end else begin
               r_state <= S_ORDER;
            end
         end else begin
            case (r_state)
               S_ORDER, S_WORD1, S_WORD2: begin
                  if (w_bit) begin
                     r_tmo <= '0;
                     if (r_state == S_ORDER) begin
                        r_order  <= r_d;
                        r_bitcnt <= 4'd0;
                        r_state  <= S_WORD1;
                     end else begin
                        r_shift  <= w_word;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd15) begin
                           if (r_state == S_WORD1) begin
                              r_w1    <= w_word;
                              r_state <= S_WORD2;
                           end else begin
                              r_w2    <= w_word;
                              r_state <= S_DONE;
                           end
                        end
                     end
                  end else if (r_tmo == TMO_LAST) begin
                     ABORT     <= 1'b1;
                     ABORT_CNT <= ABORT_CNT + CNT_W'(1);
                     r_tmo     <= '0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end
               S_DONE: begin
                  FRAME_VALID <= 1'b1;
                  ORDER_BIT   <= r_order;
                  WORD1       <= r_w1;
                  WORD2       <= r_w2;
                  PAR_ERR1    <= ~^r_w1;
                  PAR_ERR2    <= ~^r_w2;
                  FRAME_CNT   <= FRAME_CNT + CNT_W'(1);
                  r_tmo       <= '0;
                  r_bitcnt    <= 4'd0;
                  r_state     <= w_start ? S_ORDER : S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_downlink_frame_capture.sv
// Directed bench for downlink_frame_capture: serial frames, parity, restart, timeout, reset.
module tb_downlink_frame_capture;

   localparam int unsigned TIMEOUT = 512;
   localparam int unsigned CNT_W   = 16;

   logic             CLOCK = 1'b0;
   logic             rst;
   logic             DKSTRT, DKBSNC, DKDATA;
   logic             FRAME_VALID, ORDER_BIT, PAR_ERR1, PAR_ERR2, BUSY, ABORT;
   logic [15:0]      WORD1, WORD2;
   logic [CNT_W-1:0] FRAME_CNT, ABORT_CNT;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fv_cnt   = 0;
   int ab_cnt   = 0;
   int t_bit    = 0;
   int t_ab     = 0;
   logic seen;

   downlink_frame_capture #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .CLOCK       (CLOCK),
      .rst         (rst),
      .DKSTRT      (DKSTRT),
      .DKBSNC      (DKBSNC),
      .DKDATA      (DKDATA),
      .FRAME_VALID (FRAME_VALID),
      .ORDER_BIT   (ORDER_BIT),
      .WORD1       (WORD1),
      .WORD2       (WORD2),
      .PAR_ERR1    (PAR_ERR1),
      .PAR_ERR2    (PAR_ERR2),
      .BUSY        (BUSY),
      .ABORT       (ABORT),
      .FRAME_CNT   (FRAME_CNT),
      .ABORT_CNT   (ABORT_CNT)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) cyc <= cyc + 1;

   always @(negedge CLOCK) begin
      if (FRAME_VALID) fv_cnt <= fv_cnt + 1;
      if (ABORT) ab_cnt <= ab_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic d, input int hold);
      @(negedge CLOCK);
      DKDATA = d;
      DKBSNC = 1'b1;
      t_bit  = cyc;
      repeat (hold) @(negedge CLOCK);
      DKBSNC = 1'b0;
   endtask

   task automatic send_start();
      @(negedge CLOCK);
      DKSTRT = 1'b1;
      repeat (2) @(negedge CLOCK);
      DKSTRT = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits, input int hold);
      for (int i = 15; i > 15 - nbits; i--) send_bit(w[i], hold);
   endtask

   task automatic send_frame(input logic ord, input logic [15:0] w1, input logic [15:0] w2,
                             input int hold);
      send_bit(ord, hold);
      send_word(w1, 16, hold);
      send_word(w2, 16, hold);
      repeat (6) @(negedge CLOCK);
   endtask

   initial begin
      rst    = 1'b1;
      DKSTRT = 1'b0;
      DKBSNC = 1'b0;
      DKDATA = 1'b0;
      repeat (3) @(negedge CLOCK);
      chk("rst_frame_valid", 32'(FRAME_VALID), 32'd0);
      chk("rst_word1",       32'(WORD1),       32'd0);
      chk("rst_frame_cnt",   32'(FRAME_CNT),   32'd0);
      chk("rst_busy",        32'(BUSY),        32'd0);
      rst = 1'b0;
      repeat (2) @(negedge CLOCK);

      // 1: basic frame; 0x8001 has two ones (parity error), 0x7FFF has fifteen
      send_start();
      chk("t1_busy", 32'(BUSY), 32'd1);
      send_frame(1'b1, 16'h8001, 16'h7FFF, 1);
      chk("t1_fv_pulses", 32'(fv_cnt),    32'd1);
      chk("t1_order",     32'(ORDER_BIT), 32'd1);
      chk("t1_word1",     32'(WORD1),     32'h8001);
      chk("t1_word2",     32'(WORD2),     32'h7FFF);
      chk("t1_par1",      32'(PAR_ERR1),  32'd1);
      chk("t1_par2",      32'(PAR_ERR2),  32'd0);
      chk("t1_frame_cnt", 32'(FRAME_CNT), 32'd1);
      chk("t1_idle",      32'(BUSY),      32'd0);

      // 2: strobe held 5 cycles per bit; both words have odd ones counts
      send_start();
      send_frame(1'b0, 16'h0001, 16'h0007, 5);
      chk("t2_fv_pulses", 32'(fv_cnt),    32'd2);
      chk("t2_order",     32'(ORDER_BIT), 32'd0);
      chk("t2_word1",     32'(WORD1),     32'h0001);
      chk("t2_word2",     32'(WORD2),     32'h0007);
      chk("t2_par1",      32'(PAR_ERR1),  32'd0);
      chk("t2_par2",      32'(PAR_ERR2),  32'd0);
      chk("t2_frame_cnt", 32'(FRAME_CNT), 32'd2);
      chk("t2_idle",      32'(BUSY),      32'd0);

      // 3: restart after 10 bits; 0x1234 has five ones (odd, no error), 0x00FF has eight
      send_start();
      send_word(16'hFFFF, 10, 1);
      send_start();
      @(negedge CLOCK);
      chk("t3_abort_pulses", 32'(ab_cnt),    32'd1);
      chk("t3_abort_cnt",    32'(ABORT_CNT), 32'd1);
      chk("t3_busy",         32'(BUSY),      32'd1);
      chk("t3_held_word1",   32'(WORD1),     32'h0001);
      send_frame(1'b1, 16'h1234, 16'h00FF, 1);
      chk("t3_fv_pulses", 32'(fv_cnt),    32'd3);
      chk("t3_frame_cnt", 32'(FRAME_CNT), 32'd3);
      chk("t3_word1",     32'(WORD1),     32'h1234);
      chk("t3_word2",     32'(WORD2),     32'h00FF);
      chk("t3_par1",      32'(PAR_ERR1),  32'd0);
      chk("t3_par2",      32'(PAR_ERR2),  32'd1);

      // 4: strobes stop after 20 bits
      send_start();
      send_bit(1'b0, 1);
      send_word(16'hAAAA, 16, 1);
      send_word(16'h5555, 3, 1);
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge CLOCK);
         if (ABORT) begin
            seen = 1'b1;
            t_ab = cyc;
            break;
         end
      end
      chk("t4_abort_seen", 32'(seen), 32'd1);
      chk("t4_abort_latency_ok",
          32'(((t_ab - t_bit) >= TIMEOUT) && ((t_ab - t_bit) <= TIMEOUT + 3)), 32'd1);
      @(negedge CLOCK);
      chk("t4_busy",       32'(BUSY),      32'd0);
      chk("t4_abort_cnt",  32'(ABORT_CNT), 32'd2);
      chk("t4_frame_cnt",  32'(FRAME_CNT), 32'd3);
      chk("t4_held_word1", 32'(WORD1),     32'h1234);
      chk("t4_held_word2", 32'(WORD2),     32'h00FF);

      // 5: start and first bit together; 0xC3C3 has eight ones, 0x0100 has one
      @(negedge CLOCK);
      DKSTRT = 1'b1;
      DKBSNC = 1'b1;
      DKDATA = 1'b0;
      @(negedge CLOCK);
      DKBSNC = 1'b0;
      @(negedge CLOCK);
      DKSTRT = 1'b0;
      send_word(16'hC3C3, 16, 1);
      send_word(16'h0100, 15, 1);
      repeat (6) @(negedge CLOCK);
      chk("t5_not_done_early", 32'(fv_cnt), 32'd3);
      chk("t5_busy_mid",       32'(BUSY),   32'd1);
      send_bit(1'b0, 1);
      repeat (6) @(negedge CLOCK);
      chk("t5_fv_pulses", 32'(fv_cnt),    32'd4);
      chk("t5_order",     32'(ORDER_BIT), 32'd0);
      chk("t5_word1",     32'(WORD1),     32'hC3C3);
      chk("t5_word2",     32'(WORD2),     32'h0100);
      chk("t5_par1",      32'(PAR_ERR1),  32'd1);
      chk("t5_par2",      32'(PAR_ERR2),  32'd0);
      chk("t5_frame_cnt", 32'(FRAME_CNT), 32'd4);

      // 6: reset in WORD2; 0xBEEF has thirteen ones, 0x0F0F has eight
      send_start();
      send_bit(1'b1, 1);
      send_word(16'h1111, 16, 1);
      send_word(16'h2222, 5, 1);
      @(negedge CLOCK);
      rst = 1'b1;
      #1;
      chk("t6_rst_busy",      32'(BUSY),      32'd0);
      chk("t6_rst_word1",     32'(WORD1),     32'd0);
      chk("t6_rst_word2",     32'(WORD2),     32'd0);
      chk("t6_rst_order",     32'(ORDER_BIT), 32'd0);
      chk("t6_rst_par1",      32'(PAR_ERR1),  32'd0);
      chk("t6_rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
      chk("t6_rst_abort_cnt", 32'(ABORT_CNT), 32'd0);
      repeat (2) @(negedge CLOCK);
      rst = 1'b0;
      repeat (3) @(negedge CLOCK);
      chk("t6_no_abort", 32'(ab_cnt), 32'd2);
      send_start();
      send_frame(1'b1, 16'hBEEF, 16'h0F0F, 1);
      chk("t6_fv_pulses", 32'(fv_cnt),    32'd5);
      chk("t6_order",     32'(ORDER_BIT), 32'd1);
      chk("t6_word1",     32'(WORD1),     32'hBEEF);
      chk("t6_word2",     32'(WORD2),     32'h0F0F);
      chk("t6_par1",      32'(PAR_ERR1),  32'd0);
      chk("t6_par2",      32'(PAR_ERR2),  32'd1);
      chk("t6_frame_cnt", 32'(FRAME_CNT), 32'd1);
      chk("t6_abort_cnt", 32'(ABORT_CNT), 32'd0);
      chk("t6_abort_total", 32'(ab_cnt),  32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
